// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader: parses a framed big-endian byte stream,
// writes one 32-bit word per instruction and releases the CPU reset after a valid checksum.
module instr_mem_loader #(
   parameter int unsigned DEPTH     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  byte_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   output logic        load_done_o,
   output logic        load_err_o,
   output logic        cpu_rst_o,
   output logic [15:0] words_loaded_o
);

   typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR} state_t;

   state_t      state, state_nx;
   logic        accept;
   logic [15:0] cnt;
   logic [15:0] cnt_full;
   logic [15:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] asm_q;
   logic [7:0]  csum;
   logic        last_word;

   assign cnt_full  = {cnt[15:8], byte_i};
   assign last_word = (word_idx == (cnt - 16'd1));

   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= HDR_HI;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      ready_o     = 1'b0;
      load_done_o = 1'b0;
      load_err_o  = 1'b0;
      cpu_rst_o   = 1'b0;
      case (state)
         HDR_HI: begin
            ready_o = 1'b1;
            if (valid_i) state_nx = HDR_LO;
         end
         HDR_LO: begin
            ready_o = 1'b1;
            if (valid_i) begin
               if (32'(cnt_full) > DEPTH)   state_nx = ERR;
               else if (cnt_full == 16'd0) state_nx = CSUM;
               else                        state_nx = DATA;
            end
         end
         DATA: begin
            ready_o = 1'b1;
            if (valid_i && byte_cnt == 2'd3 && last_word) state_nx = CSUM;
         end
         CSUM: begin
            ready_o = 1'b1;
            if (valid_i) state_nx = (byte_i == csum) ? DONE : ERR;
         end
         DONE: begin
            load_done_o = 1'b1;
            cpu_rst_o   = 1'b1;
         end
         ERR: begin
            load_err_o = 1'b1;
         end
         default: state_nx = HDR_HI;
      endcase
      accept = valid_i && ready_o;
   end

   // Write strobe is registered, so it lands one cycle after the 4th byte and
   // may overlap acceptance of the next byte without disturbing the assembly.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         mem_we_o       <= 1'b0;
         mem_addr_o     <= BASE_ADDR;
         mem_data_o     <= '0;
         words_loaded_o <= '0;
         cnt            <= '0;
         word_idx       <= '0;
         byte_cnt       <= '0;
         asm_q          <= '0;
         csum           <= '0;
      end else begin
         mem_we_o <= 1'b0;
         if (accept) begin
            if (state != CSUM) csum <= csum ^ byte_i;
            case (state)
               HDR_HI: cnt[15:8] <= byte_i;
               HDR_LO: cnt[7:0]  <= byte_i;
               DATA: begin
                  byte_cnt <= byte_cnt + 2'd1;
                  asm_q    <= {asm_q[15:0], byte_i};
                  if (byte_cnt == 2'd3) begin
                     mem_we_o       <= 1'b1;
                     mem_data_o     <= {asm_q, byte_i};
                     mem_addr_o     <= BASE_ADDR + 32'({word_idx, 2'b00});
                     words_loaded_o <= words_loaded_o + 16'd1;
                     word_idx       <= word_idx + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
